// File: rtl/synth_seq_pkg.sv
// synth_seq_pkg: shared widths, FSM states and rest encoding for the note sequencer
package synth_seq_pkg;
  localparam int DEPTH   = 16;
  localparam int AW      = 4;
  localparam int DIV_W   = 16;
  localparam int DUR_W   = 4;
  localparam int TEMPO_W = 24;
  localparam logic [DIV_W-1:0] REST_NOTE = '0;
  typedef enum logic [1:0] {IDLE, FETCH, PLAY} state_e;
endpackage

// File: rtl/note_sequencer_if.sv
// note_sequencer_if: control, pattern-write and tone-output bundle of the note sequencer
interface note_sequencer_if;
  import synth_seq_pkg::*;
  logic [TEMPO_W-1:0] tempo_div;
  logic               wr_en;
  logic [AW-1:0]      wr_addr;
  logic [DIV_W-1:0]   wr_note;
  logic [DUR_W-1:0]   wr_dur;
  logic               start;
  logic               stop;
  logic               loop_en;
  logic               gap_en;
  logic [AW-1:0]      last_addr;
  logic [DIV_W-1:0]   div_out;
  logic               tone_en;
  logic               busy;
  logic [AW-1:0]      step_idx;
  logic               done;
  modport master (
    output tempo_div, wr_en, wr_addr, wr_note, wr_dur, start, stop, loop_en, gap_en, last_addr,
    input  div_out, tone_en, busy, step_idx, done
  );
  modport slave (
    input  tempo_div, wr_en, wr_addr, wr_note, wr_dur, start, stop, loop_en, gap_en, last_addr,
    output div_out, tone_en, busy, step_idx, done
  );
endinterface

// File: rtl/tick_gen.sv
// tick_gen: programmable clocks-per-tick divider with clear and enable
module tick_gen #(
  parameter int W = 24
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr_i,
  input  logic         en_i,
  input  logic [W-1:0] div_i,
  output logic         tick_o
);
  logic [W-1:0] cnt_q, cnt_d, term_q, term_d, term_new;
  // Terminal count is latched at clear and at each wrap, so divisor changes land on the next wrap
  assign term_new = (div_i == '0) ? '0 : div_i - 1'b1;
  assign tick_o   = en_i && (cnt_q == term_q);
  always_comb begin
    cnt_d  = clr_i ? '0 : tick_o ? '0 : en_i ? cnt_q + 1'b1 : cnt_q;
    term_d = (clr_i || tick_o) ? term_new : term_q;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q  <= '0;
      term_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      term_q <= term_d;
    end
  end
endmodule

// File: rtl/note_sequencer.sv
// note_sequencer: plays a stored (divisor, duration) pattern into the tone generator at a programmable tempo
module note_sequencer #(
  parameter int DEPTH   = synth_seq_pkg::DEPTH,
  parameter int AW      = synth_seq_pkg::AW,
  parameter int DIV_W   = synth_seq_pkg::DIV_W,
  parameter int DUR_W   = synth_seq_pkg::DUR_W,
  parameter int TEMPO_W = synth_seq_pkg::TEMPO_W
) (
  input logic              clk,
  input logic              rst,
  note_sequencer_if.slave  bus
);
  import synth_seq_pkg::*;
  state_e           state_q, state_d;
  logic [DIV_W-1:0] note_mem [DEPTH];
  logic [DUR_W-1:0] dur_mem  [DEPTH];
  logic [AW-1:0]    step_q, step_d, last_q, last_d;
  logic [DUR_W-1:0] rem_q, rem_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic             tone_q, tone_d, busy_q, busy_d, done_q, done_d;
  logic             tick;
  always_ff @(posedge clk) begin
    if (bus.wr_en) begin
      note_mem[bus.wr_addr] <= bus.wr_note;
      dur_mem[bus.wr_addr]  <= bus.wr_dur;
    end
  end
  tick_gen #(.W(TEMPO_W)) u_tick (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (state_q == FETCH),
    .en_i   (state_q == PLAY),
    .div_i  (bus.tempo_div),
    .tick_o (tick)
  );
  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    last_d  = last_q;
    rem_d   = rem_q;
    div_d   = div_q;
    tone_d  = tone_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    if (state_q != IDLE && bus.stop) begin
      state_d = IDLE;
      tone_d  = 1'b0;
      busy_d  = 1'b0;
    end else begin
      case (state_q)
        IDLE: if (bus.start && !bus.stop) begin
          last_d  = bus.last_addr;
          step_d  = '0;
          busy_d  = 1'b1;
          state_d = FETCH;
        end
        FETCH: begin
          div_d   = note_mem[step_q];
          tone_d  = note_mem[step_q] != REST_NOTE;
          rem_d   = dur_mem[step_q];
          state_d = PLAY;
        end
        PLAY: if (tick) begin
          if (rem_q == '0) begin
            if (step_q != last_q) begin
              step_d  = step_q + 1'b1;
              state_d = FETCH;
            end else if (bus.loop_en) begin
              step_d  = '0;
              state_d = FETCH;
            end else begin
              state_d = IDLE;
              tone_d  = 1'b0;
              busy_d  = 1'b0;
              done_d  = 1'b1;
            end
          end else begin
            rem_d = rem_q - 1'b1;
            // Entering the last tick of a multi-tick note: articulation gap
            if (bus.gap_en && rem_q == DUR_W'(1)) tone_d = 1'b0;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      step_q  <= '0;
      last_q  <= '0;
      rem_q   <= '0;
      div_q   <= '0;
      tone_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      last_q  <= last_d;
      rem_q   <= rem_d;
      div_q   <= div_d;
      tone_q  <= tone_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end
  assign bus.div_out  = div_q;
  assign bus.tone_en  = tone_q;
  assign bus.busy     = busy_q;
  assign bus.step_idx = step_q;
  assign bus.done     = done_q;
endmodule

// File: doc/note_sequencer.md
Name: note_sequencer

Overview:
- Plays a stored melody by programming the tone divider: steps through a small pattern memory of (half-period divisor, duration) entries at a programmable tempo.
- Each note's divisor is presented to the downstream tone generator with a tone enable, which forms a programmable version of the fixed divide-by-16 clock divider.
- Sits between the user/keypad control logic and the tone generator. Provides start/stop/loop control and an optional articulation gap.

Parameters:
- DEPTH, 16, pattern entries (power of two)
- AW, 4, address width, log2(DEPTH)
- DIV_W, 16, tone half-period divisor width
- DUR_W, 4, note duration field width
- TEMPO_W, 24, clocks-per-tick counter width

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-low
- tempo_div  in  TEMPO_W  clocks per tick; 0 is treated as 1
- wr_en  in  1  pattern write strobe
- wr_addr  in  AW  pattern write address
- wr_note  in  DIV_W  divisor; 0 means rest
- wr_dur  in  DUR_W  duration code d; the note lasts d+1 ticks
- start  in  1  begin playback at entry 0
- stop  in  1  abort playback
- loop_en  in  1  wrap to entry 0 after last_addr
- gap_en  in  1  silence the final tick of each note of length 2 or more
- last_addr  in  AW  final entry index, latched at start
- div_out  out  DIV_W  divisor to the tone generator
- tone_en  out  1  tone generator enable
- busy  out  1  high outside IDLE
- step_idx  out  AW  index of the current entry
- done  out  1  one-cycle pulse at natural end of pattern

Behaviour:
- Reset (rst=0): div_out=0, tone_en=0, busy=0, step_idx=0, done=0, state IDLE, tick counter 0, latched last_addr 0. Pattern memory is not cleared. All outputs are registered.
- Pattern memory:
  - Synchronous write; writes are accepted in any state.
  - A write to an entry that is currently playing does not affect that note, because its fields are already latched. It takes effect on the next fetch of that entry.
- Tick generation:
  - The counter counts 0..max(tempo_div,1)-1 and asserts tick on the terminal count.
  - It runs only in PLAY and is cleared on entry to PLAY.
  - tempo_div changes take effect at the next wrap.
- States: IDLE, FETCH, PLAY.
- IDLE:
  - start=1 and stop=0: latch last_addr, step_idx=0, go to FETCH, busy=1.
- FETCH (exactly 1 cycle):
  - Read entry[step_idx]; load remaining=wr_dur field; go to PLAY.
  - On this edge div_out = note and tone_en = (note != 0).
  - Latency: start sampled at edge E0 gives FETCH after E0 and div_out/tone_en valid after E1.
  - During FETCH, div_out and tone_en hold their previous values.
- PLAY:
  - Each tick decrements remaining.
  - If gap_en=1, remaining reaches 0 and d >= 1, then tone_en=0 for the final tick, while div_out holds.
  - On a tick with remaining=0 the note ends:
    - step_idx != latched last: step_idx += 1, go to FETCH.
    - step_idx == latched last and loop_en=1: step_idx=0, go to FETCH. loop_en is sampled at this edge.
    - step_idx == latched last and loop_en=0: go to IDLE with tone_en=0, busy=0, done=1 for one cycle. div_out holds.
- stop:
  - From any non-IDLE state, stop goes to IDLE at the next edge with tone_en=0 and busy=0. No done pulse; step_idx holds.
  - stop in IDLE has no effect.
- Simultaneous events:
  - start while busy is ignored.
  - start and stop together: stop wins.
  - stop on the note-end tick: stop wins, no done.
- Boundaries:
  - last_addr=0 plays a single entry.
  - step_idx wraps only through loop_en. It never exceeds the latched last.
  - A rest entry (note=0) keeps tone_en=0 for its full duration.
- Reset mid-playback returns to the reset values immediately, asynchronously.

Decomposition:
- Package synth_seq_pkg:
  - state enumeration (IDLE, FETCH, PLAY)
  - default widths DIV_W, DUR_W, TEMPO_W
  - REST_NOTE = 0
- Sub-module tick_gen: programmable clocks-per-tick counter with clear and enable inputs and a tick output. It is the parameterised successor of the fixed clock divider.
- Pattern memory is inferred inside note_sequencer.

Test Plan:
- Reset, then write entries 0..2 = (100,d0), (200,d1), (0,d0); tempo_div=4, last_addr=2, loop_en=0, start:
  - div_out=100 with tone_en=1 for 4 clocks, then 200 for 8 clocks, then tone_en=0 (rest) for 4 clocks.
  - Then a single done pulse and busy=0. Each FETCH adds 1 clock.
- Same pattern with loop_en=1:
  - after entry 2, step_idx returns to 0 and div_out=100 again.
  - loop_en dropped mid-entry-1 gives done after entry 2.
- gap_en=1, entry (300,d3), tempo_div=2: tone_en is high for 6 clocks then low for 2. An entry with d0 has no gap.
- Stop asserted mid-PLAY of entry 1: next edge gives tone_en=0 and busy=0 with no done. Start and stop asserted together in IDLE: busy stays 0.
- Write entry 1 := (500,d0) while entry 1 is playing: the current note stays at its old divisor; on the next loop pass div_out=500.
- tempo_div=0: a tick every clock, so d0 lasts 1 clock. rst pulsed low mid-note: all outputs go to 0 asynchronously.
